// File: rtl/miner_dispatch_ctrl.sv
// Multi-core nonce dispatcher: hands out consecutive nonces to NUM_CORES hash cores per round
// and reports the lowest winning nonce. Optional watchdog enabled by `define MINER_WATCHDOG_EN.

module miner_dispatch_lane #(
  parameter int NW  = 32,
  parameter int IDX = 0
) (
  input  logic [NW-1:0] base,
  input  logic [NW-1:0] end_n,
  input  logic          active,
  input  logic          core_done,
  input  logic          core_hit,
  output logic [NW-1:0] nonce,
  output logic          act_nxt,
  output logic          new_done,
  output logic          new_hit
);
  logic [NW:0] sum;

  // One extra bit so ranges ending at all-ones never wrap back into the range.
  assign sum      = {1'b0, base} + (NW+1)'(IDX);
  assign nonce    = sum[NW-1:0];
  assign act_nxt  = sum <= {1'b0, end_n};
  assign new_done = active & core_done;
  assign new_hit  = active & core_done & core_hit;
endmodule

module miner_dispatch_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int NONCE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             data_ready,
  input  logic [NONCE_WIDTH-1:0]           nonce_start,
  input  logic [NONCE_WIDTH-1:0]           nonce_end,
  input  logic                             abort,
  input  logic [NUM_CORES-1:0]             core_done,
  input  logic [NUM_CORES-1:0]             core_hit,
  input  logic                             result_ack,
  output logic [NUM_CORES-1:0]             hash_enable,
  output logic [NUM_CORES*NONCE_WIDTH-1:0] core_nonce,
  output logic                             busy,
  output logic                             result_valid,
  output logic                             found,
  output logic [NONCE_WIDTH-1:0]           found_nonce,
  output logic                             timeout_err
);
  localparam int NW = NONCE_WIDTH;
  localparam logic [NW:0] NC_W = (NW+1)'(NUM_CORES);

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT, CHECK, REPORT} state_t;
  typedef struct packed {
    logic          found;
    logic [NW-1:0] nonce;
  } res_t;

  state_t                          state_q, state_d;
  logic [NW-1:0]                   base_q, base_d, end_q, end_d;
  logic [NUM_CORES-1:0]            act_q, act_d, done_q, done_d, hit_q, hit_d;
  logic [NUM_CORES-1:0][NW-1:0]    nonce_q, nonce_d;
  res_t                            res_q, res_d;

  logic [NUM_CORES-1:0][NW-1:0]    lane_nonce;
  logic [NUM_CORES-1:0]            lane_act, lane_done, lane_hit;
  logic                            last_round;
  logic [NW-1:0]                   win_nonce;

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
      miner_dispatch_lane #(.NW(NW), .IDX(i)) u_lane (
        .base     (base_d),
        .end_n    (end_d),
        .active   (act_q[i]),
        .core_done(core_done[i]),
        .core_hit (core_hit[i]),
        .nonce    (lane_nonce[i]),
        .act_nxt  (lane_act[i]),
        .new_done (lane_done[i]),
        .new_hit  (lane_hit[i])
      );
    end
  endgenerate

  assign last_round = ({1'b0, base_q} + NC_W) > {1'b0, end_q};

  // Held core nonces are base+i, so the lowest hit lane's nonce is the winner.
  always_comb begin
    win_nonce = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (hit_q[i]) win_nonce = nonce_q[i];
  end

`ifdef MINER_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES+1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Range mux kept apart from the FSM so the lanes see next-round base without a loop.
  always_comb begin
    base_d = base_q;
    end_d  = end_q;
    if (!abort) begin
      if (data_ready && state_q != REPORT) begin
        base_d = nonce_start;
        end_d  = nonce_end;
      end else if (state_q == CHECK && hit_q == '0 && !last_round) begin
        base_d = base_q + NW'(NUM_CORES);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    nonce_d = nonce_q;
    done_d  = done_q;
    hit_d   = hit_q;
    res_d   = res_q;
`ifdef MINER_WATCHDOG_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
`endif
    if (abort) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        act_d   = '0;
        done_d  = '0;
        hit_d   = '0;
        res_d   = '0;
`ifdef MINER_WATCHDOG_EN
        tmo_d   = 1'b0;
`endif
      end
    end else if (data_ready && state_q != REPORT) begin
      state_d = (state_q == IDLE && nonce_start > nonce_end) ? REPORT : DISPATCH;
      res_d   = '0;
    end else begin
      case (state_q)
        DISPATCH: begin
          done_d  = '0;
          hit_d   = '0;
          state_d = WAIT;
`ifdef MINER_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
        WAIT: begin
          done_d = done_q | lane_done;
          hit_d  = hit_q | lane_hit;
`ifdef MINER_WATCHDOG_EN
          wdog_d = wdog_q + 1'b1;
`endif
          if (done_d == act_q) begin
            state_d = CHECK;
          end
`ifdef MINER_WATCHDOG_EN
          // Fires on the TIMEOUT_CYCLES-th WAIT cycle; partial hits are dropped.
          else if (wdog_q == WDW'(TIMEOUT_CYCLES-1)) begin
            state_d = REPORT;
            hit_d   = '0;
            res_d   = '0;
            tmo_d   = 1'b1;
          end
`endif
        end
        CHECK: begin
          if (hit_q != '0) begin
            res_d.found = 1'b1;
            res_d.nonce = win_nonce;
            state_d     = REPORT;
          end else if (last_round) begin
            state_d = REPORT;
          end else begin
            state_d = DISPATCH;
          end
        end
        REPORT: begin
          if (result_ack) begin
            res_d   = '0;
            state_d = IDLE;
`ifdef MINER_WATCHDOG_EN
            tmo_d   = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
    if (state_d == DISPATCH) begin
      act_d   = lane_act;
      nonce_d = lane_nonce;
      done_d  = '0;
      hit_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      end_q   <= '0;
      act_q   <= '0;
      done_q  <= '0;
      hit_q   <= '0;
      nonce_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      end_q   <= end_d;
      act_q   <= act_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      nonce_q <= nonce_d;
      res_q   <= res_d;
    end
  end

`ifdef MINER_WATCHDOG_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == REPORT);
  assign hash_enable  = (state_q == DISPATCH) ? act_q : '0;
  assign core_nonce   = nonce_q;
  assign found        = res_q.found;
  assign found_nonce  = res_q.nonce;
endmodule
